// File: rtl/sram_input_streamer_pkg.sv
// Shared FSM encoding and header layout for the SRAM input streamer.
package sram_input_streamer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_HDR0   = 3'd1;
    localparam state_t ST_HDR1   = 3'd2;
    localparam state_t ST_CHECK  = 3'd3;
    localparam state_t ST_STREAM = 3'd4;
    localparam state_t ST_DRAIN  = 3'd5;
    localparam state_t ST_DONE   = 3'd6;

    localparam int HDR_COUNT_OFS = 0;
    localparam int HDR_SIZE_OFS  = 1;
    localparam int DATA_OFS      = 2;

    // Largest word count that fits after the two header words.
    function automatic logic [31:0] max_total(input int addr_w);
        return (32'd1 << addr_w) - 32'd2;
    endfunction

endpackage

// File: rtl/sram_input_streamer_skid_fifo.sv
// Small power-of-two FIFO that absorbs words already in flight from the SRAM.
module stream_skid_fifo #(
    parameter int W     = 18,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [W-1:0]     i_data,
    output logic [W-1:0]     o_data,
    output logic [PTR_W:0]   o_count,
    output logic             o_empty,
    output logic             o_full
);
    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (PTR_W+1)'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sram_input_streamer.sv
// Reads a two-word header from input SRAM and streams count*size words downstream.
// Optional stall counter port stall_cycles is built when INPUT_STREAMER_PERF_EN is defined.
module sram_input_streamer
    import sram_input_streamer_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] sram_read_address,
    input  logic [DATA_W-1:0] sram_read_data,
    output logic              hdr_valid,
    output logic [DATA_W-1:0] num_inputs,
    output logic [DATA_W-1:0] input_size,
    // Stream handshake: a word transfers on any cycle with out_valid && out_ready;
    // while out_valid is high and out_ready low, data/last/eos hold steady.
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              out_eos,
`ifdef INPUT_STREAMER_PERF_EN
    output logic [15:0]       stall_cycles,
`endif
    output state_t            dbg_state
);
    localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] MAX_TOTAL = max_total(ADDR_W);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W-1:0] r_issue_left;
    logic [DATA_W-1:0] r_vec_idx;
    logic [DATA_W-1:0] r_num_inputs;
    logic [DATA_W-1:0] r_input_size;
    logic              r_hdr_valid;
    logic              r_err;
    logic              r_tag;
    logic              r_tag_last;
    logic              r_tag_eos;
    logic [31:0]       w_total;
    logic              w_check_go;
    logic              w_credit;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_issue_eos;
    logic [DATA_W-1:0] w_vec_base;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count;
    logic              w_empty;
    logic              w_full;
    logic [DATA_W+1:0] w_fifo_out;

    // Size word is still on the SRAM data bus during CHECK.
    assign w_total    = 32'(r_num_inputs) * 32'(sram_read_data);
    assign w_check_go = (w_total != 32'd0) && (w_total <= MAX_TOTAL);
    assign w_pop      = out_valid && out_ready;
    // Count a popping slot as free so a held-high out_ready sustains one word per cycle.
    assign w_credit   = (int'(w_count) + int'(r_tag) - int'(w_pop)) < FIFO_DEPTH;
    assign w_issue    = ((r_state == ST_CHECK) && w_check_go) ||
                        ((r_state == ST_STREAM) && w_credit && (r_issue_left != '0));
    assign w_vec_base = (r_state == ST_CHECK) ? '0 : r_vec_idx;

    always_comb begin
        w_issue_last = 1'b0;
        w_issue_eos  = 1'b0;
        if (r_state == ST_CHECK) begin
            w_issue_last = (sram_read_data == DATA_W'(1));
            w_issue_eos  = (w_total == 32'd1);
        end else begin
            w_issue_last = (r_vec_idx == r_input_size - DATA_W'(1));
            w_issue_eos  = (r_issue_left == ADDR_W'(1));
        end
    end

    always_comb begin
        case (r_state)
            ST_HDR1:   sram_read_address = ADDR_W'(BASE_ADDR + HDR_SIZE_OFS);
            ST_CHECK:  sram_read_address = w_check_go ? ADDR_W'(BASE_ADDR + DATA_OFS)
                                                      : ADDR_W'(BASE_ADDR + HDR_SIZE_OFS);
            ST_STREAM: sram_read_address = r_rd_ptr;
            ST_DRAIN:  sram_read_address = r_rd_ptr;
            default:   sram_read_address = ADDR_W'(BASE_ADDR + HDR_COUNT_OFS);
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_next_state = ST_HDR0;
            ST_HDR0:   w_next_state = ST_HDR1;
            ST_HDR1:   w_next_state = ST_CHECK;
            ST_CHECK: begin
                if (!w_check_go)            w_next_state = ST_DONE;
                else if (w_total == 32'd1)  w_next_state = ST_DRAIN;
                else                        w_next_state = ST_STREAM;
            end
            ST_STREAM: if (w_issue && (r_issue_left == ADDR_W'(1))) w_next_state = ST_DRAIN;
            ST_DRAIN:  if (w_pop && out_eos) w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state      <= ST_IDLE;
            r_rd_ptr     <= '0;
            r_issue_left <= '0;
            r_vec_idx    <= '0;
            r_num_inputs <= '0;
            r_input_size <= '0;
            r_hdr_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_tag        <= 1'b0;
            r_tag_last   <= 1'b0;
            r_tag_eos    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_tag      <= w_issue;
            r_tag_last <= w_issue && w_issue_last;
            r_tag_eos  <= w_issue && w_issue_eos;
            if ((r_state == ST_IDLE) && start) begin
                r_err       <= 1'b0;
                r_hdr_valid <= 1'b0;
            end
            if (r_state == ST_HDR1) r_num_inputs <= sram_read_data;
            if (r_state == ST_CHECK) begin
                r_input_size <= sram_read_data;
                r_hdr_valid  <= 1'b1;
                if (w_total > MAX_TOTAL) r_err <= 1'b1;
            end
            if (w_issue) begin
                if (r_state == ST_CHECK) begin
                    r_rd_ptr     <= ADDR_W'(BASE_ADDR + DATA_OFS + 1);
                    r_issue_left <= ADDR_W'(w_total - 32'd1);
                end else begin
                    r_rd_ptr     <= r_rd_ptr + ADDR_W'(1);
                    r_issue_left <= r_issue_left - ADDR_W'(1);
                end
                r_vec_idx <= w_issue_last ? '0 : w_vec_base + DATA_W'(1);
            end
        end
    end

    stream_skid_fifo #(
        .W     (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_b (reset_b),
        .i_push  (r_tag),
        .i_pop   (w_pop),
        .i_data  ({r_tag_last, r_tag_eos, sram_read_data}),
        .o_data  (w_fifo_out),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assign out_valid  = !w_empty;
    assign out_last   = w_fifo_out[DATA_W+1];
    assign out_eos    = w_fifo_out[DATA_W];
    assign out_data   = w_fifo_out[DATA_W-1:0];
    assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done       = (r_state == ST_DONE);
    assign err        = r_err;
    assign hdr_valid  = r_hdr_valid;
    assign num_inputs = r_num_inputs;
    assign input_size = r_input_size;
    assign dbg_state  = r_state;

`ifdef INPUT_STREAMER_PERF_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_stall_cycles <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_stall_cycles <= '0;
        end else if (busy && out_valid && !out_ready && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_sram_input_streamer.sv
// Bench for sram_input_streamer: table of header cases, randomized transfers, and
// hand-written reset-abort and start-while-busy sequences against a stream model.
module tb_sram_input_streamer;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 16;
    localparam int MAX_TOTAL = (1 << ADDR_W) - 2;

    typedef struct {
        int n;
        int s;
        int mode;
        bit exp_err;
        int exp_words;
        bit seq;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset_b = 1'b0;
    logic              start = 1'b0;
    logic              out_ready = 1'b0;
    logic              busy, done, err, hdr_valid;
    logic [ADDR_W-1:0] sram_read_address;
    logic [DATA_W-1:0] sram_read_data;
    logic [DATA_W-1:0] num_inputs, input_size;
    logic              out_valid, out_last, out_eos;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        dbg_state;
`ifdef INPUT_STREAMER_PERF_EN
    logic [15:0]       stall_cycles;
`endif

    logic [DATA_W-1:0] mem [1 << ADDR_W];
    logic [DATA_W+1:0] exp_q [$];

    int n_total = 0;
    int n_bad = 0;
    int cyc = 0;
    int ready_mode = 0;
    int pat_idx = 0;
    logic [3:0] ready_pat = 4'b1001;
    int accepted, done_cnt, first_valid_cyc, eos_cyc, done_cyc, model_stall;
    logic [ADDR_W-1:0] max_addr;
    vec_t vecs [10];

    sram_input_streamer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(0), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .reset_b(reset_b), .start(start), .busy(busy), .done(done), .err(err),
        .sram_read_address(sram_read_address), .sram_read_data(sram_read_data),
        .hdr_valid(hdr_valid), .num_inputs(num_inputs), .input_size(input_size),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_eos(out_eos),
`ifdef INPUT_STREAMER_PERF_EN
        .stall_cycles(stall_cycles),
`endif
        .dbg_state(dbg_state)
    );

    // Clock, cycle counter and synchronous SRAM model.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) sram_read_data <= mem[sram_read_address];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Ready driver, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = ready_pat[pat_idx % 4];
                    pat_idx++;
                end
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard / monitor, sampled mid-cycle.
    initial begin
        logic hold;
        logic [DATA_W+1:0] held, got, want;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (!reset_b) begin
                hold = 1'b0;
                continue;
            end
            got = {out_last, out_eos, out_data};
            if (sram_read_address > max_addr) max_addr = sram_read_address;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (busy && out_valid && !out_ready) model_stall++;
            if (hold) begin
                check("held valid", 64'(out_valid), 64'd1);
                check("held word", 64'(got), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL extra word: got 0x%0h with no word expected", got);
                end else begin
                    want = exp_q.pop_front();
                    check("stream word", 64'(got), 64'(want));
                end
                accepted++;
                if (out_eos) eos_cyc = cyc;
            end
            hold = out_valid && !out_ready;
            held = got;
        end
    end

    // Reference stream: word i is mem[2+i]; last closes each vector of s words.
    task automatic build_expected(input int n, input int s);
        int tot;
        tot = n * s;
        exp_q.delete();
        if (tot == 0 || tot > MAX_TOTAL) return;
        for (int i = 0; i < tot; i++)
            exp_q.push_back({((i % s) == s - 1), (i == tot - 1), mem[2 + i]});
    endtask

    task automatic load_header(input int n, input int s, input bit seq);
        int tot;
        tot = n * s;
        mem[0] = DATA_W'(n);
        mem[1] = DATA_W'(s);
        if (tot > 0 && tot <= MAX_TOTAL)
            for (int i = 0; i < tot; i++)
                mem[2 + i] = seq ? DATA_W'(16'h100 + i) : DATA_W'($urandom);
        build_expected(n, s);
    endtask

    task automatic clear_counters();
        accepted = 0;
        done_cnt = 0;
        first_valid_cyc = -1;
        eos_cyc = -1;
        done_cyc = -1;
        max_addr = '0;
        model_stall = 0;
    endtask

    task automatic check_all_zero(input string name);
        check({name, " busy"}, 64'(busy), 64'd0);
        check({name, " done"}, 64'(done), 64'd0);
        check({name, " err"}, 64'(err), 64'd0);
        check({name, " hdr"}, {hdr_valid, num_inputs, input_size}, 64'd0);
        check({name, " stream"}, {out_valid, out_last, out_eos, out_data}, 64'd0);
        check({name, " addr"}, 64'(sram_read_address), 64'd0);
`ifdef INPUT_STREAMER_PERF_EN
        check({name, " stalls"}, 64'(stall_cycles), 64'd0);
`endif
    endtask

    task automatic run_transfer(input int n, input int s, input int mode, input bit exp_err,
                                input int exp_words, input bit seq, input bit extra_start);
        int k, budget, start_cyc;
        load_header(n, s, seq);
        ready_mode = mode;
        pat_idx = 0;
        clear_counters();
        budget = 4 * exp_words + 100;
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        start_cyc = cyc;
        check("busy after start", 64'(busy), 64'd1);
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(posedge clk);
            k++;
            if (extra_start && k == 5) begin
                #2 start = 1'b1;
                @(posedge clk);
                #2 start = 1'b0;
                k++;
            end
        end
        if (done_cnt == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL done timeout: got no done in %0d cycles, required one", budget);
        end
        repeat (3) @(posedge clk);
        #2;
        check("done pulses", 64'(done_cnt), 64'd1);
        check("err", 64'(err), 64'(exp_err));
        check("hdr_valid", 64'(hdr_valid), 64'd1);
        check("num_inputs", 64'(num_inputs), 64'(n));
        check("input_size", 64'(input_size), 64'(s));
        check("words accepted", 64'(accepted), 64'(exp_words));
        check("words left", 64'(exp_q.size()), 64'd0);
        check("idle after done", 64'(busy), 64'd0);
        if (exp_words > 0) begin
            check("first valid latency", 64'(first_valid_cyc - start_cyc), 64'd4);
            check("done after eos", 64'(done_cyc - eos_cyc), 64'd1);
        end else begin
            check("max address", 64'(max_addr), 64'd1);
        end
`ifdef INPUT_STREAMER_PERF_EN
        check("stall_cycles", 64'(stall_cycles), 64'(model_stall));
`endif
    endtask

    initial begin
        int k, n, s;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
        clear_counters();

        vecs[0] = '{3, 4, 0, 1'b0, 12, 1'b1};
        vecs[1] = '{3, 4, 1, 1'b0, 12, 1'b1};
        vecs[2] = '{0, 5, 0, 1'b0, 0, 1'b0};
        vecs[3] = '{256, 32, 0, 1'b1, 0, 1'b0};
        vecs[4] = '{1, 1, 2, 1'b0, 1, 1'b0};
        vecs[5] = '{2, 2047, 0, 1'b0, 4094, 1'b0};
        vecs[6] = '{1, 4095, 0, 1'b1, 0, 1'b0};
        vecs[7] = '{5, 0, 0, 1'b0, 0, 1'b0};
        vecs[8] = '{4, 3, 2, 1'b0, 12, 1'b0};
        vecs[9] = '{1, 7, 2, 1'b0, 7, 1'b0};

        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        reset_b = 1'b1;

        for (int v = 0; v < 10; v++)
            run_transfer(vecs[v].n, vecs[v].s, vecs[v].mode, vecs[v].exp_err,
                         vecs[v].exp_words, vecs[v].seq, 1'b0);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(1, 5);
            s = $urandom_range(1, 6);
            run_transfer(n, s, 2, 1'b0, n * s, 1'b0, 1'b0);
        end

        // start while busy must be ignored
        run_transfer(3, 4, 1, 1'b0, 12, 1'b1, 1'b1);

        // reset after the fifth accepted word aborts without a done pulse
        load_header(3, 4, 1'b1);
        ready_mode = 0;
        clear_counters();
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        k = 0;
        while (accepted < 5 && k < 100) begin
            @(posedge clk);
            k++;
        end
        check("words before abort", 64'(accepted), 64'd5);
        #2 reset_b = 1'b0;
        #1;
        check_all_zero("abort");
        repeat (3) @(posedge clk);
        #2 reset_b = 1'b1;
        check("done during abort", 64'(done_cnt), 64'd0);
        exp_q.delete();
        run_transfer(3, 4, 0, 1'b0, 12, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_input_streamer.md
Name: sram_input_streamer

Overview:
Upstream feeder for the compute datapath. On a start pulse it reads the two-word header from input SRAM: word 0 = number of input vectors, word 1 = words per vector. It then streams count*size data words to the consumer over a valid/ready handshake, hiding the 1-cycle SRAM read latency with a small skid FIFO. This frees the compute core from SRAM address sequencing.

Parameters:
ADDR_W, 12, SRAM address width
DATA_W, 16, SRAM/stream word width
BASE_ADDR, 0, SRAM address of header word 0
FIFO_DEPTH, 2, skid FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock, rising edge
reset_b  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse; begins a transfer when idle
busy  out  1  high from cycle after accepted start until done pulse
done  out  1  1-cycle pulse when the last word is accepted, or on error/empty
err  out  1  sticky: count*size exceeds address space; cleared by next accepted start
sram_read_address  out  ADDR_W  input SRAM read address
sram_read_data  in  DATA_W  read data, valid 1 cycle after address
hdr_valid  out  1  high once both header words are captured; held until next start
num_inputs  out  DATA_W  captured header word 0
input_size  out  DATA_W  captured header word 1
out_valid  out  1  stream word available
out_ready  in  1  consumer accepts when valid&ready
out_data  out  DATA_W  stream word
out_last  out  1  marks the last word of each vector (qualified by out_valid)
out_eos  out  1  marks the final word of the transfer (qualified by out_valid)

Behaviour:
- Reset (async, reset_b low): state IDLE, FIFO empty, all outputs 0, sram_read_address = BASE_ADDR.
- States: IDLE -> HDR0 -> HDR1 -> CHECK -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE: start=1 -> HDR0, busy=1 next cycle, err and hdr_valid cleared. start is ignored in every other state.
- HDR0: drive BASE_ADDR. HDR1: drive BASE_ADDR+1 and capture num_inputs from sram_read_data.
- CHECK: capture input_size and set hdr_valid. Compute total = num_inputs*input_size (32-bit unsigned).
  - total==0 -> DONE.
  - total > 2^ADDR_W-2 -> set err, go to DONE.
  - Otherwise STREAM with rd_ptr=BASE_ADDR+2 and words_left=total.
- STREAM: issue a read when fifo_count + inflight < FIFO_DEPTH and issued < total. The tag bit enables an FIFO write one cycle later.
  - Each pushed entry carries data, last, and eos flags.
  - last = (word index within vector == input_size-1). eos = final word.
  - When all reads are issued -> DRAIN.
- DRAIN: wait until the eos word is popped (out_valid&out_ready&out_eos) -> DONE.
- DONE: done=1 for one cycle, busy=0 -> IDLE. Captured header values are held.
- FIFO: out_valid = !empty; pop on valid&ready. Push and pop in the same cycle are both legal. No push ever overflows, which the credit rule guarantees.
- Throughput: 1 word/cycle when out_ready is held high. First out_valid comes 4 cycles after start.
- Backpressure: a word is never dropped or duplicated. out_data, out_last and out_eos stay stable while out_valid&!out_ready.
- Reset mid-transfer aborts immediately. No done pulse; FIFO is flushed.
- Address arithmetic wraps modulo 2^ADDR_W. The err check guarantees no wrap during a legal transfer.

Optional Feature:
Macro INPUT_STREAMER_PERF_EN.
- Defined: adds output stall_cycles[15:0].
  - Counts cycles with out_valid&!out_ready during busy. Saturates at 16'hFFFF.
  - Cleared on accepted start.
- Undefined: port and counter absent; no other behaviour changes.

Decomposition:
- Shared package: state enum (IDLE, HDR0, HDR1, CHECK, STREAM, DRAIN, DONE) and header offset constants (HDR_COUNT_OFS=0, HDR_SIZE_OFS=1, DATA_OFS=2).
- One sub-module, stream_skid_fifo: parameterised DATA_W+2 bits wide, FIFO_DEPTH deep, with push, pop, count, empty and full.

Test Plan:
- Header 3,4 with data 0x100..0x10B and out_ready=1 -> 12 words in order, one per cycle after first valid.
  - out_last on 0x103, 0x107 and 0x10B; out_eos only on 0x10B.
  - done one cycle after 0x10B is accepted; err=0.
- Same header, out_ready toggling 1,0,0,1 -> identical data sequence, no loss or duplication, data held stable during stalls. With PERF_EN, stall_cycles equals the counted stall cycles.
- Header 0,5 -> hdr_valid=1, no out_valid, done pulses, err=0.
- Header 0x0100,0x0020 (total 8192 > 4094) -> err=1, done pulses, no out_valid, sram_read_address never exceeds BASE_ADDR+1.
- reset_b low after the 5th word of a 3x4 transfer -> all outputs 0 immediately and no done pulse. A new start runs a clean full transfer.
- start pulsed while busy -> ignored; transfer completes unchanged with a single done pulse.
